matrix_scan_controller: RTL
===========================

Name: matrix_scan_controller

Overview:
Sequences one HUB75-style 32x32 RGB matrix panel: requests a 32-column shift from the column-filler datapath, blanks the panel, latches the shifted row, drives the row address, then holds the output enabled for a bit-plane-weighted dwell time. It implements binary-coded modulation over PLANES bit planes and 16 row pairs. It sits between the frame buffer read logic and the column filler, and drives the LAT/OE/A-D pins of the panel.

Parameters:
ROW_PAIRS, 16, number of row pairs scanned (row_addr wraps at ROW_PAIRS-1)
PLANES, 4, number of BCM bit planes per row (plane 0 = LSB)
BASE_TICKS, 64, display dwell in clk cycles for plane 0; plane p dwells BASE_TICKS<<p
BLANK_CYCLES, 4, clk cycles OE held inactive before latch (anti-ghosting)
LATCH_CYCLES, 2, clk cycles lat held high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run scanning; low parks the controller in IDLE at the next safe point
fill_done  in  1  column filler has shifted all 32 columns (level or pulse)
fill_start  out  1  one-cycle pulse: column filler begins shifting fill_row/fill_plane
fill_row  out  $clog2(ROW_PAIRS)  row pair whose data is being shifted
fill_plane  out  $clog2(PLANES)  bit plane being shifted
row_addr  out  $clog2(ROW_PAIRS)  panel A-D address
lat  out  1  panel latch strobe, active high
oe_n  out  1  panel output enable, active low
frame_done  out  1  one-cycle pulse after the last plane of the last row pair finishes displaying

Behaviour:
- Reset (async, immediate): state IDLE; fill_start=0, fill_row=0, fill_plane=0, row_addr=0, lat=0, oe_n=1, frame_done=0; all counters 0.
- All outputs registered. States: IDLE, FILL, BLANK, LATCH, DISPLAY.
- IDLE: oe_n=1, lat=0. enable=1 -> FILL.
- FILL: fill_start=1 in the first FILL cycle only. fill_done is ignored in that cycle and sampled from the following cycle; first sampled fill_done=1 -> BLANK. No timeout. oe_n=1 throughout FILL (sequential fill, no overlap with display).
- BLANK: oe_n=1 for exactly BLANK_CYCLES cycles. On the last BLANK cycle, row_addr <= fill_row. Then -> LATCH.
- LATCH: lat=1 for exactly LATCH_CYCLES cycles, oe_n=1. Then -> DISPLAY.
- DISPLAY: oe_n=0 for exactly BASE_TICKS<<fill_plane cycles. On the final cycle, advance the counters:
  - fill_plane+1.
  - On plane wrap (PLANES-1 -> 0), fill_row+1.
  - On row wrap (ROW_PAIRS-1 -> 0), pulse frame_done for one cycle, coincident with the first cycle of the next state.
  - Next state is FILL if enable=1, otherwise IDLE. The plane/row advance still occurs when entering IDLE, so scanning resumes at the next plane.
- enable is checked only in IDLE and at the end of DISPLAY. Deassertion during FILL, BLANK or LATCH completes the current row/plane.
- fill_done asserted outside FILL is ignored. A level held high from the previous row does not satisfy the new FILL until the cycle after fill_start.
- Dwell counter width: $clog2(BASE_TICKS<<(PLANES-1))+1. Counts down from the load value to 1 with no overflow.
- oe_n is never 0 while lat=1, and never 0 in any state other than DISPLAY.
- An asynchronous reset mid-DISPLAY forces oe_n=1 in the same instant, with no glitch to 0.

Decomposition:
- Shared package matrix_pkg:
  - scan_state_t enum {IDLE, FILL, BLANK, LATCH, DISPLAY}
  - MATRIX_COLS=32
  - ROW_PAIRS_DEFAULT=16
  - PLANES_DEFAULT=4
- One sub-module, dwell_timer: loadable down-counter with a load value and a one-cycle expire pulse.
  - Async active-high reset.
  - Reused for the BLANK, LATCH and DISPLAY durations.

Test Plan:
Use ROW_PAIRS=2, PLANES=2, BASE_TICKS=4, BLANK_CYCLES=2, LATCH_CYCLES=1 unless noted.
1. Reset, then enable=1, with fill_done returned 3 cycles after fill_start -> expected sequence:
   - fill_start for 1 cycle
   - oe_n=1 for 2 BLANK cycles, with row_addr=0 at the latch
   - lat=1 for 1 cycle
   - oe_n=0 for exactly 4 cycles (plane 0)
   - then a new fill_start with fill_plane=1
2. Continue the run -> dwell lengths are plane0=4 and plane1=8 cycles. After the row 1 plane 1 dwell, frame_done pulses exactly once and fill_row=0, fill_plane=0. Across the frame, row_addr shows 0,0,1,1 at the four latches.
3. fill_done tied high permanently -> each FILL lasts exactly 2 cycles (start cycle plus 1 sampled cycle). Checker confirms no skipped rows or planes.
4. Drop enable during LATCH -> DISPLAY completes its full dwell, then IDLE with oe_n=1 and counters advanced. Re-enabling resumes at the next plane.
5. Assert reset asynchronously mid-DISPLAY (between clock edges) -> oe_n=1 and lat=0 immediately, with all counters 0. After release plus enable, the sequence restarts at row 0, plane 0.
6. Assertion checker run with defaults for 2 frames:
   - oe_n=0 only in DISPLAY, never together with lat=1
   - frame_done count = 2
   - total DISPLAY cycles per frame = 16*64*(1+2+4+8) = 15360

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the HUB75 matrix scan controller.
package matrix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int unsigned MATRIX_COLS       = 32;
  localparam int unsigned ROW_PAIRS_DEFAULT = 16;
  localparam int unsigned PLANES_DEFAULT    = 4;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; o_expire_c is high for the single cycle the count sits at 1.
module dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire_c
);

  logic [W-1:0] r_count;

  // Load wins over counting; counting stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire_c = (r_count == W'(1));

endmodule

// File: rtl/matrix_scan_controller.sv
// HUB75 panel sequencer: fill -> blank -> latch -> BCM-weighted display per row pair and plane.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int unsigned ROW_PAIRS    = ROW_PAIRS_DEFAULT,
  parameter int unsigned PLANES       = PLANES_DEFAULT,
  parameter int unsigned BASE_TICKS   = 64,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         fill_done,
  output logic                         fill_start,
  output logic [$clog2(ROW_PAIRS)-1:0] fill_row,
  output logic [$clog2(PLANES)-1:0]    fill_plane,
  output logic [$clog2(ROW_PAIRS)-1:0] row_addr,
  output logic                         lat,
  output logic                         oe_n,
  output logic                         frame_done
);

  localparam int unsigned RW = $clog2(ROW_PAIRS);
  localparam int unsigned PW = $clog2(PLANES);
  localparam int unsigned DW = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

  scan_state_t r_state;
  scan_state_t w_next_state;

  logic          r_fill_start;
  logic [RW-1:0] r_fill_row;
  logic [PW-1:0] r_fill_plane;
  logic [RW-1:0] r_row_addr;
  logic          r_lat;
  logic          r_oe_n;
  logic          r_frame_done;

  logic          w_load;
  logic [DW-1:0] w_load_val;
  logic [DW-1:0] w_dwell_load;
  logic          w_expire;
  logic          w_advance;
  logic          w_plane_wrap;
  logic          w_row_wrap;
  logic          w_frame_end;
  logic [PW-1:0] w_plane_next;
  logic [RW-1:0] w_row_next;

  // One timer shared by BLANK, LATCH and DISPLAY; loaded on entry to each.
  dwell_timer #(
    .W (DW)
  ) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire_c (w_expire)
  );

  assign w_dwell_load = DW'(BASE_TICKS) << r_fill_plane;
  assign w_plane_wrap = (r_fill_plane == PW'(PLANES - 1));
  assign w_row_wrap   = (r_fill_row == RW'(ROW_PAIRS - 1));
  assign w_plane_next = w_plane_wrap ? '0 : r_fill_plane + PW'(1);
  assign w_row_next   = w_plane_wrap ? (w_row_wrap ? '0 : r_fill_row + RW'(1)) : r_fill_row;
  assign w_frame_end  = w_advance && w_plane_wrap && w_row_wrap;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and timer load control.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_next_state = FILL;
      end
      FILL: begin
        // fill_start is high only in the first FILL cycle, where fill_done is not trusted.
        if (!r_fill_start && fill_done) begin
          w_next_state = BLANK;
          w_load       = 1'b1;
          w_load_val   = DW'(BLANK_CYCLES);
        end
      end
      BLANK: begin
        if (w_expire) begin
          w_next_state = LATCH;
          w_load       = 1'b1;
          w_load_val   = DW'(LATCH_CYCLES);
        end
      end
      LATCH: begin
        if (w_expire) begin
          w_next_state = DISPLAY;
          w_load       = 1'b1;
          w_load_val   = w_dwell_load;
        end
      end
      DISPLAY: begin
        if (w_expire) begin
          w_advance    = 1'b1;
          w_next_state = enable ? FILL : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Registered panel/filler outputs derived from the state being entered, plus scan counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill_start <= 1'b0;
      r_fill_row   <= '0;
      r_fill_plane <= '0;
      r_row_addr   <= '0;
      r_lat        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_fill_start <= (w_next_state == FILL) && (r_state != FILL);
      r_lat        <= (w_next_state == LATCH);
      r_oe_n       <= (w_next_state != DISPLAY);
      r_frame_done <= w_frame_end;
      if (w_advance) begin
        r_fill_plane <= w_plane_next;
        r_fill_row   <= w_row_next;
      end
      if ((r_state == BLANK) && w_expire) begin
        r_row_addr <= r_fill_row;
      end
    end
  end

  assign fill_start = r_fill_start;
  assign fill_row   = r_fill_row;
  assign fill_plane = r_fill_plane;
  assign row_addr   = r_row_addr;
  assign lat        = r_lat;
  assign oe_n       = r_oe_n;
  assign frame_done = r_frame_done;

endmodule
